mem2p_port_arbiter: RTL and testbench

- Round-robin arbiter sharing the native single-cycle port pair of a two-port block memory (one write port, one read port) between G_NUM_REQ requesters.
- Sits between several native-port masters (AXI slave front-ends, DMA engines, init loaders) and one blockmem_2p_wrapper instance.
- Read and write ports are arbitrated independently.
- Each read is tagged so its data is routed back to the issuing requester after the fixed memory read latency.

---
 rtl/mem2p_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem2p_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem2p_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem2p_port_arbiter: round-robin sharing of a two-port block memory's  |
// | write and read ports among G_NUM_REQ native-port requesters.          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem2p_port_arbiter #(
  parameter int G_NUM_REQ    = 2,
  parameter int G_DATAWIDTH  = 32,
  parameter int G_ADDRWIDTH  = 10,
  parameter int G_WEWIDTH    = ((G_DATAWIDTH-1)/8)+1,
  parameter int G_RD_LATENCY = 1
) (
  input  logic                             s_aclk,
  input  logic                             s_aresetn,
  input  logic [G_NUM_REQ-1:0]             req_wr,
  input  logic [G_NUM_REQ*G_ADDRWIDTH-1:0] req_waddr,
  input  logic [G_NUM_REQ*G_DATAWIDTH-1:0] req_wdata,
  input  logic [G_NUM_REQ*G_WEWIDTH-1:0]   req_wstrb,
  output logic [G_NUM_REQ-1:0]             req_wgnt,
  input  logic [G_NUM_REQ-1:0]             req_rd,
  input  logic [G_NUM_REQ*G_ADDRWIDTH-1:0] req_raddr,
  output logic [G_NUM_REQ-1:0]             req_rgnt,
  output logic [G_NUM_REQ-1:0]             req_rvalid,
  output logic [G_DATAWIDTH-1:0]           req_rdata,
  output logic                             mem_wr,
  output logic [G_ADDRWIDTH-1:0]           mem_waddr,
  output logic [G_DATAWIDTH-1:0]           mem_wdata,
  output logic [G_WEWIDTH-1:0]             mem_wstrb,
  output logic                             mem_rd,
  output logic [G_ADDRWIDTH-1:0]           mem_raddr,
  input  logic [G_DATAWIDTH-1:0]           mem_rdata
);

  localparam int C_PTRW = $clog2(G_NUM_REQ);

  logic [G_ADDRWIDTH-1:0] w_waddr_arr [G_NUM_REQ];
  logic [G_DATAWIDTH-1:0] w_wdata_arr [G_NUM_REQ];
  logic [G_WEWIDTH-1:0]   w_wstrb_arr [G_NUM_REQ];
  logic [G_ADDRWIDTH-1:0] w_raddr_arr [G_NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < G_NUM_REQ; gi++) begin : g_slice
      assign w_waddr_arr[gi] = req_waddr[gi*G_ADDRWIDTH +: G_ADDRWIDTH];
      assign w_wdata_arr[gi] = req_wdata[gi*G_DATAWIDTH +: G_DATAWIDTH];
      assign w_wstrb_arr[gi] = req_wstrb[gi*G_WEWIDTH +: G_WEWIDTH];
      assign w_raddr_arr[gi] = req_raddr[gi*G_ADDRWIDTH +: G_ADDRWIDTH];
    end
  endgenerate

  // Returns {found, index}: scanning offsets high-to-low lets the closest
  // requester at or after the pointer overwrite any farther one.
  function automatic logic [C_PTRW:0] f_pick(input logic [G_NUM_REQ-1:0] req,
                                             input logic [C_PTRW-1:0]    ptr);
    logic [C_PTRW-1:0] idx;
    f_pick = '0;
    for (int off = G_NUM_REQ-1; off >= 0; off--) begin
      idx = C_PTRW'((int'(ptr) + off) % G_NUM_REQ);
      if (req[idx]) f_pick = {1'b1, idx};
    end
  endfunction

  function automatic logic [C_PTRW-1:0] f_next(input logic [C_PTRW-1:0] idx);
    return (int'(idx) == G_NUM_REQ-1) ? '0 : idx + 1'b1;
  endfunction

  logic [C_PTRW-1:0] r_wptr, r_rptr;
  logic [C_PTRW:0]   w_wpick, w_rpick;
  logic              w_wfound, w_rfound;
  logic [C_PTRW-1:0] w_widx, w_ridx;

  logic [G_RD_LATENCY-1:0] r_tag_vld;
  logic [C_PTRW-1:0]       r_tag_idx [G_RD_LATENCY];

  // Gating with reset keeps grants and memory strobes low while held in reset.
  assign w_wpick  = f_pick(req_wr & {G_NUM_REQ{s_aresetn}}, r_wptr);
  assign w_rpick  = f_pick(req_rd & {G_NUM_REQ{s_aresetn}}, r_rptr);
  assign w_wfound = w_wpick[C_PTRW];
  assign w_widx   = w_wpick[C_PTRW-1:0];
  assign w_rfound = w_rpick[C_PTRW];
  assign w_ridx   = w_rpick[C_PTRW-1:0];

  assign req_wgnt  = w_wfound ? (G_NUM_REQ'(1) << w_widx) : '0;
  assign req_rgnt  = w_rfound ? (G_NUM_REQ'(1) << w_ridx) : '0;

  assign mem_wr    = w_wfound;
  assign mem_waddr = w_wfound ? w_waddr_arr[w_widx] : '0;
  assign mem_wdata = w_wfound ? w_wdata_arr[w_widx] : '0;
  assign mem_wstrb = w_wfound ? w_wstrb_arr[w_widx] : '0;
  assign mem_rd    = w_rfound;
  assign mem_raddr = w_rfound ? w_raddr_arr[w_ridx] : '0;

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_tag_vld <= '0;
      for (int i = 0; i < G_RD_LATENCY; i++) r_tag_idx[i] <= '0;
    end else begin
      if (w_wfound) r_wptr <= f_next(w_widx);
      if (w_rfound) r_rptr <= f_next(w_ridx);
      r_tag_vld[0] <= w_rfound;
      r_tag_idx[0] <= w_ridx;
      for (int i = 1; i < G_RD_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
    end
  end

  // The last tag stage lines up with mem_rdata of the read it describes.
  assign req_rvalid = r_tag_vld[G_RD_LATENCY-1] ?
                      (G_NUM_REQ'(1) << r_tag_idx[G_RD_LATENCY-1]) : '0;
  assign req_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem2p_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem2p_port_arbiter: directed bench with a read-first memory model. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mem2p_port_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int WW  = 4;
  localparam int LAT = 2;

  logic s_aclk = 1'b0;
  always #5 s_aclk = ~s_aclk;

  logic            s_aresetn;
  logic [N-1:0]    req_wr, req_wgnt, req_rd, req_rgnt, req_rvalid;
  logic [N*AW-1:0] req_waddr, req_raddr;
  logic [N*DW-1:0] req_wdata;
  logic [N*WW-1:0] req_wstrb;
  logic [DW-1:0]   req_rdata, mem_wdata, mem_rdata;
  logic            mem_wr, mem_rd;
  logic [AW-1:0]   mem_waddr, mem_raddr;
  logic [WW-1:0]   mem_wstrb;

  mem2p_port_arbiter #(
    .G_NUM_REQ(N), .G_DATAWIDTH(DW), .G_ADDRWIDTH(AW),
    .G_WEWIDTH(WW), .G_RD_LATENCY(LAT)
  ) dut (
    .s_aclk(s_aclk), .s_aresetn(s_aresetn),
    .req_wr(req_wr), .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_wgnt(req_wgnt),
    .req_rd(req_rd), .req_raddr(req_raddr), .req_rgnt(req_rgnt),
    .req_rvalid(req_rvalid), .req_rdata(req_rdata),
    .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rd(mem_rd), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata)
  );

  // Read-first two-port memory with LAT cycles of read latency.
  bit   [DW-1:0] mem_q   [1<<AW];
  bit            written [1<<AW];
  logic [DW-1:0] rd_pipe [LAT];
  logic [DW-1:0] mdl_word;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return 32'h1000_0000 | DW'(a);
  endfunction

  always @(posedge s_aclk) begin
    rd_pipe[0] <= written[mem_raddr] ? mem_q[mem_raddr] : init_word(mem_raddr);
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_wr) begin
      mdl_word = written[mem_waddr] ? mem_q[mem_waddr] : init_word(mem_waddr);
      for (int b = 0; b < WW; b++)
        if (mem_wstrb[b]) mdl_word[8*b +: 8] = mem_wdata[8*b +: 8];
      mem_q[mem_waddr]   <= mdl_word;
      written[mem_waddr] <= 1'b1;
    end
  end
  assign mem_rdata = rd_pipe[LAT-1];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    req_wr = '0; req_rd = '0; req_waddr = '0; req_raddr = '0;
    req_wdata = '0; req_wstrb = '0;
  endtask

  task automatic set_w(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [WW-1:0] s);
    req_wr[i] = 1'b1;
    req_waddr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_wstrb[i*WW +: WW] = s;
  endtask

  task automatic set_r(input int i, input logic [AW-1:0] a);
    req_rd[i] = 1'b1;
    req_raddr[i*AW +: AW] = a;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wgnt"}, DW'(req_wgnt), '0);
    chk({tag, "_rgnt"}, DW'(req_rgnt), '0);
    chk({tag, "_mem_wr"}, DW'(mem_wr), '0);
    chk({tag, "_mem_rd"}, DW'(mem_rd), '0);
    chk({tag, "_waddr"}, DW'(mem_waddr), '0);
    chk({tag, "_raddr"}, DW'(mem_raddr), '0);
    chk({tag, "_rvalid"}, DW'(req_rvalid), '0);
  endtask

  logic [N-1:0] exp_v;
  logic [DW-1:0] exp_d;
  int           eidx;

  initial begin
    // Reset held with every request asserted: nothing may be granted.
    s_aresetn = 1'b0;
    clr();
    for (int i = 0; i < N; i++) begin set_w(i, AW'(i), 32'hFFFF_FFFF, 4'hF); set_r(i, AW'(i)); end
    #2;
    chk_idle("reset");
    @(negedge s_aclk);
    @(negedge s_aclk);

    // Single write granted in the first cycle after release.
    s_aresetn = 1'b1;
    clr(); set_w(1, 10'h010, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk("wr1_gnt", DW'(req_wgnt), 32'b0010);
    chk("wr1_mem_wr", DW'(mem_wr), 1);
    chk("wr1_waddr", DW'(mem_waddr), 32'h10);
    chk("wr1_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("wr1_wstrb", DW'(mem_wstrb), 32'hF);
    chk("wr1_no_rd", DW'(mem_rd), 0);

    @(negedge s_aclk); clr(); set_r(0, 10'h010); #1;
    chk("rd1_gnt", DW'(req_rgnt), 32'b0001);
    chk("rd1_raddr", DW'(mem_raddr), 32'h10);
    @(negedge s_aclk); clr(); #1;
    chk("rd1_early", DW'(req_rvalid), 0);
    @(negedge s_aclk); #1;
    chk("rd1_rvalid", DW'(req_rvalid), 32'b0001);
    chk("rd1_rdata", req_rdata, 32'hDEAD_BEEF);
    @(negedge s_aclk); #1;
    chk("rd1_done", DW'(req_rvalid), 0);

    // Fairness: write pointer sits at 2, so order is 2,3,0,1,2.
    for (int c = 0; c < 5; c++) begin
      @(negedge s_aclk); clr();
      for (int i = 0; i < N; i++) set_w(i, AW'(10'h020 + i), 32'hC0DE_0000 + i, 4'hF);
      #1;
      eidx = (2 + c) % N;
      chk($sformatf("fair%0d_gnt", c), DW'(req_wgnt), DW'(1) << eidx);
      chk($sformatf("fair%0d_waddr", c), DW'(mem_waddr), 32'h20 + eidx);
      chk($sformatf("fair%0d_wdata", c), mem_wdata, 32'hC0DE_0000 + eidx);
    end

    // Zero strobe is still granted and issued; memory content unchanged.
    @(negedge s_aclk); clr(); set_w(0, 10'h020, 32'hFFFF_FFFF, 4'h0); #1;
    chk("strb0_gnt", DW'(req_wgnt), 32'b0001);
    chk("strb0_mem_wr", DW'(mem_wr), 1);
    chk("strb0_wstrb", DW'(mem_wstrb), 0);

    // Read contention between 0 and 1, read pointer at 1.
    for (int c = 0; c < 8; c++) begin
      @(negedge s_aclk); clr();
      if (c < 6) begin set_r(0, 10'h010); set_r(1, 10'h021); end
      #1;
      chk($sformatf("cont%0d_gnt", c), DW'(req_rgnt),
          (c < 6) ? ((c % 2 == 0) ? 32'b0010 : 32'b0001) : 32'b0);
      if (c >= LAT) begin
        exp_v = ((c - LAT) % 2 == 0) ? 4'b0010 : 4'b0001;
        exp_d = ((c - LAT) % 2 == 0) ? 32'hC0DE_0001 : 32'hDEAD_BEEF;
        chk($sformatf("cont%0d_rvalid", c), DW'(req_rvalid), DW'(exp_v));
        chk($sformatf("cont%0d_rdata", c), req_rdata, exp_d);
      end else begin
        chk($sformatf("cont%0d_rvalid", c), DW'(req_rvalid), 0);
      end
    end

    // Back-to-back reads from requester 2: data returns in issue order.
    for (int c = 0; c < 7; c++) begin
      @(negedge s_aclk); clr();
      if (c < 4) set_r(2, AW'(10'h020 + c));
      #1;
      chk($sformatf("burst%0d_gnt", c), DW'(req_rgnt), (c < 4) ? 32'b0100 : 32'b0);
      if (c >= LAT && c < LAT + 4) begin
        chk($sformatf("burst%0d_rvalid", c), DW'(req_rvalid), 32'b0100);
        chk($sformatf("burst%0d_rdata", c), req_rdata, 32'hC0DE_0000 + (c - LAT));
      end else begin
        chk($sformatf("burst%0d_rvalid", c), DW'(req_rvalid), 0);
      end
    end

    // Same-cycle write and read of one address: read-first.
    @(negedge s_aclk); clr();
    set_w(0, 10'h005, 32'hA5A5_A5A5, 4'h3); set_r(1, 10'h005); #1;
    chk("sim_wgnt", DW'(req_wgnt), 32'b0001);
    chk("sim_rgnt", DW'(req_rgnt), 32'b0010);
    chk("sim_wstrb", DW'(mem_wstrb), 32'h3);
    chk("sim_raddr", DW'(mem_raddr), 32'h5);
    @(negedge s_aclk); clr(); set_r(1, 10'h005); #1;
    chk("sim2_rgnt", DW'(req_rgnt), 32'b0010);
    chk("sim2_rvalid", DW'(req_rvalid), 0);
    @(negedge s_aclk); clr(); #1;
    chk("sim_old_rvalid", DW'(req_rvalid), 32'b0010);
    chk("sim_old_rdata", req_rdata, 32'h1000_0005);
    @(negedge s_aclk); #1;
    chk("sim_new_rvalid", DW'(req_rvalid), 32'b0010);
    chk("sim_new_rdata", req_rdata, 32'h1000_A5A5);

    // Reset mid-flight: read from 2 in flight, pointers both move to 3.
    @(negedge s_aclk); clr();
    set_r(2, 10'h010); set_w(2, 10'h030, 32'h1234_5678, 4'hF); #1;
    chk("pre_rgnt", DW'(req_rgnt), 32'b0100);
    chk("pre_wgnt", DW'(req_wgnt), 32'b0100);
    @(negedge s_aclk); clr();
    for (int i = 0; i < N; i++) begin set_w(i, AW'(10'h040 + i), 32'h0, 4'hF); set_r(i, 10'h010); end
    #1;
    chk("ptr3_wgnt", DW'(req_wgnt), 32'b1000);
    chk("ptr3_rgnt", DW'(req_rgnt), 32'b1000);
    s_aresetn = 1'b0;
    #1;
    chk_idle("midrst");
    clr();
    #1 s_aresetn = 1'b1;
    @(negedge s_aclk); clr();
    for (int i = 0; i < N; i++) begin set_w(i, AW'(10'h040 + i), 32'h0, 4'hF); set_r(i, 10'h010); end
    #1;
    chk("post_wgnt", DW'(req_wgnt), 32'b0001);
    chk("post_rgnt", DW'(req_rgnt), 32'b0001);
    chk("post_dropped", DW'(req_rvalid), 0);
    @(negedge s_aclk); clr(); #1;
    chk("post_quiet", DW'(req_rvalid), 0);
    @(negedge s_aclk); #1;
    chk("post_rvalid", DW'(req_rvalid), 32'b0001);
    chk("post_rdata", req_rdata, 32'hDEAD_BEEF);
    @(negedge s_aclk); #1;
    chk("post_done", DW'(req_rvalid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
